// File: rtl/usg_ingress_buffer.sv
// -----------------------------------------------------------------------------
// usg_ingress_buffer
//
// Purpose: ingress packet buffer ahead of the L4 parser. Packet words are
// queued in a first-word-fall-through data FIFO; a per-packet verdict
// (forward / discard) is queued in a small first-word-fall-through valid
// FIFO. A three-state FSM pops one verdict per packet and then either
// forwards the packet words (registered, one per cycle) or silently drains
// them.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   pktin_data_wr       input word strobe
//   pktin_data          input word: [w_pkt-1:w_pkt-2] tag (01 hdr, 11 body,
//                       10 tail), [131:128] invalid type, [127:0] data
//   pktin_data_valid_wr per-packet verdict strobe (at or after tail word)
//   pktin_data_valid    verdict: 1 = forward, 0 = discard
//   pktin_ready         registered: upstream may start a new packet
//   pktout_data_wr      output word strobe
//   pktout_data         output word (registered)
//   pktout_ready        downstream accepts a new packet (sampled in IDLE only)
//   pkt_fwd_cnt         packets forwarded
//   pkt_drop_cnt        packets discarded on verdict 0
//   ovf_cnt             words lost because the data FIFO was full
// -----------------------------------------------------------------------------
module usg_ingress_buffer #(
    parameter int w_pkt  = 134,
    parameter int DW_AW  = 8,
    parameter int VF_AW  = 4,
    parameter int RDY_TH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pktin_data_wr,
    input  logic [w_pkt-1:0] pktin_data,
    input  logic             pktin_data_valid_wr,
    input  logic             pktin_data_valid,
    output logic             pktin_ready,
    output logic             pktout_data_wr,
    output logic [w_pkt-1:0] pktout_data,
    input  logic             pktout_ready,
    output logic [31:0]      pkt_fwd_cnt,
    output logic [31:0]      pkt_drop_cnt,
    output logic [31:0]      ovf_cnt
);

    localparam int          DW_DEPTH = 1 << DW_AW;
    localparam int          VF_DEPTH = 1 << VF_AW;
    localparam logic [1:0]  TAG_TAIL = 2'b10;
    localparam logic [31:0] RDY_TH_U = RDY_TH;
    localparam logic [DW_AW:0] DW_ONE  = {{DW_AW{1'b0}}, 1'b1};
    localparam logic [VF_AW:0] VF_ONE  = {{VF_AW{1'b0}}, 1'b1};
    localparam logic [DW_AW:0] DW_SIZE = {1'b1, {DW_AW{1'b0}}};
    localparam logic [VF_AW:0] VF_SIZE = {1'b1, {VF_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Storage arrays and pointers; pointers carry one extra MSB so that
    // full and empty are distinguishable when the address bits match.
    logic [w_pkt-1:0] r_dmem [DW_DEPTH];
    logic             r_vmem [VF_DEPTH];
    logic [DW_AW:0]   r_dwr_ptr;
    logic [DW_AW:0]   r_drd_ptr;
    logic [VF_AW:0]   r_vwr_ptr;
    logic [VF_AW:0]   r_vrd_ptr;

    state_t           r_state;
    logic             r_pktin_ready;
    logic             r_out_wr;
    logic [w_pkt-1:0] r_out_data;
    logic [31:0]      r_fwd_cnt;
    logic [31:0]      r_drop_cnt;
    logic [31:0]      r_ovf_cnt;

    logic             w_df_empty;
    logic             w_df_full;
    logic [DW_AW:0]   w_df_cnt;
    logic [DW_AW:0]   w_df_free;
    logic             w_vf_empty;
    logic             w_vf_full;
    logic [VF_AW:0]   w_vf_cnt;
    logic [VF_AW:0]   w_vf_free;
    logic [31:0]      w_df_free_ext;
    logic [31:0]      w_vf_free_ext;
    logic             w_df_push;
    logic             w_vf_push;
    logic             w_df_pop;
    logic             w_vf_pop;
    logic [w_pkt-1:0] w_df_head;
    logic             w_vf_head;
    logic             w_is_tail;

    assign w_df_empty = (r_dwr_ptr == r_drd_ptr);
    assign w_df_full  = (r_dwr_ptr[DW_AW] != r_drd_ptr[DW_AW]) &&
                        (r_dwr_ptr[DW_AW-1:0] == r_drd_ptr[DW_AW-1:0]);
    assign w_df_cnt   = r_dwr_ptr - r_drd_ptr;
    assign w_df_free  = DW_SIZE - w_df_cnt;
    assign w_vf_empty = (r_vwr_ptr == r_vrd_ptr);
    assign w_vf_full  = (r_vwr_ptr[VF_AW] != r_vrd_ptr[VF_AW]) &&
                        (r_vwr_ptr[VF_AW-1:0] == r_vrd_ptr[VF_AW-1:0]);
    assign w_vf_cnt   = r_vwr_ptr - r_vrd_ptr;
    assign w_vf_free  = VF_SIZE - w_vf_cnt;
    assign w_df_free_ext = 32'(w_df_free);
    assign w_vf_free_ext = 32'(w_vf_free);

    // Writes arriving while full are dropped (data drops are counted).
    assign w_df_push = pktin_data_wr && !w_df_full;
    assign w_vf_push = pktin_data_valid_wr && !w_vf_full;

    // First-word-fall-through heads.
    assign w_df_head = r_dmem[r_drd_ptr[DW_AW-1:0]];
    assign w_vf_head = r_vmem[r_vrd_ptr[VF_AW-1:0]];
    assign w_is_tail = (w_df_head[w_pkt-1 -: 2] == TAG_TAIL);

    // Pop decisions: verdicts only in IDLE (gated by downstream ready),
    // data words in SEND/DISCARD whenever available (stall when empty).
    always_comb begin
        w_df_pop = 1'b0;
        w_vf_pop = 1'b0;
        case (r_state)
            ST_IDLE:    w_vf_pop = !w_vf_empty && pktout_ready;
            ST_SEND:    w_df_pop = !w_df_empty;
            ST_DISCARD: w_df_pop = !w_df_empty;
            default: begin
                w_df_pop = 1'b0;
                w_vf_pop = 1'b0;
            end
        endcase
    end

    // FIFO storage arrays (no reset, contents qualified by the pointers).
    always_ff @(posedge clk) begin
        if (w_df_push) begin
            r_dmem[r_dwr_ptr[DW_AW-1:0]] <= pktin_data;
        end
        if (w_vf_push) begin
            r_vmem[r_vwr_ptr[VF_AW-1:0]] <= pktin_data_valid;
        end
    end

    // Pointers, FSM, registered outputs and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwr_ptr     <= '0;
            r_drd_ptr     <= '0;
            r_vwr_ptr     <= '0;
            r_vrd_ptr     <= '0;
            r_state       <= ST_IDLE;
            r_pktin_ready <= 1'b0;
            r_out_wr      <= 1'b0;
            r_out_data    <= '0;
            r_fwd_cnt     <= 32'd0;
            r_drop_cnt    <= 32'd0;
            r_ovf_cnt     <= 32'd0;
        end else begin
            if (w_df_push) r_dwr_ptr <= r_dwr_ptr + DW_ONE;
            if (w_df_pop)  r_drd_ptr <= r_drd_ptr + DW_ONE;
            if (w_vf_push) r_vwr_ptr <= r_vwr_ptr + VF_ONE;
            if (w_vf_pop)  r_vrd_ptr <= r_vrd_ptr + VF_ONE;

            if (pktin_data_wr && w_df_full) begin
                r_ovf_cnt <= r_ovf_cnt + 32'd1;
            end

            // Two free verdict slots leave room for the packet in flight
            // plus one that was already committed when ready was sampled.
            r_pktin_ready <= (w_df_free_ext >= RDY_TH_U) &&
                             (w_vf_free_ext >= 32'd2);

            r_out_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vf_pop) begin
                        r_state <= w_vf_head ? ST_SEND : ST_DISCARD;
                    end
                end
                ST_SEND: begin
                    if (w_df_pop) begin
                        r_out_wr   <= 1'b1;
                        r_out_data <= w_df_head;
                        if (w_is_tail) begin
                            r_fwd_cnt <= r_fwd_cnt + 32'd1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_df_pop && w_is_tail) begin
                        r_drop_cnt <= r_drop_cnt + 32'd1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pktin_ready    = r_pktin_ready;
    assign pktout_data_wr = r_out_wr;
    assign pktout_data    = r_out_data;
    assign pkt_fwd_cnt    = r_fwd_cnt;
    assign pkt_drop_cnt   = r_drop_cnt;
    assign ovf_cnt        = r_ovf_cnt;

endmodule

// File: doc/usg_ingress_buffer.md
USG_INGRESS_BUFFER -- requirements
Module: usg_ingress_buffer

Interface
REQ-001 Parameter w_pkt, default 134: packet word width; [133:132] tag (01 header, 11 body, 10 tail), [131:128] invalid type, [127:0] data.
REQ-002 Parameter DW_AW, default 8: data FIFO address width (256 words).
REQ-003 Parameter VF_AW, default 4: valid-flag FIFO address width (16 entries).
REQ-004 Parameter RDY_TH, default 128: minimum free data-FIFO words for pktin_ready.
REQ-005 Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- pktin_data_wr  in  1  input word strobe
- pktin_data  in  w_pkt  input word
- pktin_data_valid_wr  in  1  per-packet verdict strobe, at or after tail word
- pktin_data_valid  in  1  1 = forward packet, 0 = discard
- pktin_ready  out  1  upstream may start a new packet
- pktout_data_wr  out  1  output word strobe, feeds the L4 parser stage input
- pktout_data  out  w_pkt  output word
- pktout_ready  in  1  downstream accepts a new packet
- pkt_fwd_cnt  out  32  packets forwarded
- pkt_drop_cnt  out  32  packets discarded on verdict 0
- ovf_cnt  out  32  words lost to data-FIFO overflow

Function
REQ-006 The block SHALL store words in a first-word-fall-through data FIFO and verdicts in a first-word-fall-through valid FIFO, writing on pktin_data_wr and pktin_data_valid_wr respectively.
REQ-007 pktin_ready SHALL be a registered 1 when free data-FIFO words >= RDY_TH and the valid FIFO has >= 2 free entries; else 0.
REQ-008 The block SHALL drop a pktin_data_wr word arriving while the data FIFO is full and increment ovf_cnt; it SHALL drop a verdict arriving while the valid FIFO is full with no count.
REQ-009 The FSM SHALL have states IDLE, SEND, DISCARD; reset state IDLE.
REQ-010 IDLE: if the valid FIFO is non-empty and pktout_ready=1, pop one verdict; go to SEND if 1, DISCARD if 0; otherwise stay in IDLE.
REQ-011 SEND: if the data FIFO is non-empty, pop one word per cycle and drive it registered on pktout_data with pktout_data_wr=1 the next cycle; on popping a tail word (tag 10), increment pkt_fwd_cnt and return to IDLE.
REQ-012 DISCARD: if the data FIFO is non-empty, pop one word per cycle with pktout_data_wr=0; on popping a tail word, increment pkt_drop_cnt and return to IDLE.
REQ-013 pktout_ready SHALL be sampled only in IDLE; once SEND is entered, the packet SHALL be emitted without pause.
REQ-014 SEND/DISCARD with an empty data FIFO SHALL stall with no pop and no output strobe.
REQ-015 Latency: verdict written at cycle t with data already stored -> verdict popped at t+1, first word popped at t+2, pktout_data_wr=1 at t+3; then one word per cycle.
REQ-016 Simultaneous FIFO write and read in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-017 Pointers SHALL wrap modulo depth; full/empty SHALL be derived from an extra pointer MSB.
REQ-018 Counters SHALL wrap from 2^32-1 to 0.
REQ-019 Back-to-back packets SHALL have at least one IDLE cycle between a tail word and the next header.

Reset
REQ-020 On reset, the FSM SHALL go to IDLE; both FIFOs SHALL be emptied; pktout_data_wr=0, pktout_data=0, pktin_ready=0 (1 from the next cycle), and all counters 0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet; no partial words SHALL be output after reset.

Verification
REQ-022 A 4-word packet (01,11,11,10) with verdict 1 and pktout_ready=1 -> 4 contiguous output words identical to input, first at t+3 after the verdict; pkt_fwd_cnt=1.
REQ-023 A 3-word packet with verdict 0, then a 2-word packet with verdict 1 -> only the 2-word packet appears at the output; pkt_drop_cnt=1, pkt_fwd_cnt=1.
REQ-024 pktout_ready=0 with 2 packets queued -> no output; ready raised -> both packets emitted, separated by >= 1 idle cycle.
REQ-025 Fill 129 words without reading -> pktin_ready=0 (127 free); write 128 more -> ovf_cnt=1 (data FIFO holds 256).
REQ-026 Reset asserted at the 2nd word of a 5-word SEND -> outputs 0 the next cycle, FIFOs empty, a later fresh packet is forwarded correctly.
